// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped write-back data cache controller for the MEM
//               stage, with stall output and req/ack line-transfer port.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int LINES      = 4,
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic              is_byte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              block_pipe_data_cache,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wline,
  input  logic [127:0]      mem_rline,
  input  logic              mem_ack
);

  localparam int c_OFF_W = $clog2(LINE_BYTES);
  localparam int c_IDX_W = $clog2(LINES);
  localparam int c_TAG_W = ADDR_W - c_OFF_W - c_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVICT = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [LINES-1:0]     r_valid;
  logic [LINES-1:0]     r_dirty;
  logic [c_TAG_W-1:0]   r_tag  [LINES];
  logic [127:0]         r_data [LINES];
  logic [c_IDX_W-1:0]   r_req_idx;
  logic [c_TAG_W-1:0]   r_req_tag;

  logic [c_IDX_W-1:0]   w_idx;
  logic [c_TAG_W-1:0]   w_tag;
  logic [1:0]           w_word;
  logic [1:0]           w_lane;
  logic                 w_access;
  logic                 w_hit;
  logic                 w_miss_idle;
  logic                 w_store_hit;
  logic                 w_fill_done;
  logic [127:0]         w_line;
  logic [127:0]         w_wline;
  logic [31:0]          w_rword;
  logic [7:0]           w_rbyte;

  assign w_idx    = addr[c_OFF_W +: c_IDX_W];
  assign w_tag    = addr[ADDR_W-1 -: c_TAG_W];
  assign w_word   = addr[3:2];
  assign w_lane   = addr[1:0];
  assign w_access = MEM_R_EN | MEM_W_EN;
  assign w_hit    = w_access & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

  assign w_miss_idle = (r_state == ST_IDLE) & w_access & ~w_hit;
  assign w_store_hit = (r_state == ST_IDLE) & w_hit & MEM_W_EN;
  assign w_fill_done = (r_state == ST_FILL) & mem_ack;

  assign w_line  = r_data[w_idx];
  assign w_rword = w_line[{w_word, 5'b00000} +: 32];
  assign w_rbyte = w_rword[{w_lane, 3'b000} +: 8];

  always_comb begin
    w_wline = w_line;
    if (is_byte) begin
      w_wline[{w_word, w_lane, 3'b000} +: 8] = wdata[7:0];
    end else begin
      w_wline[{w_word, 5'b00000} +: 32] = wdata;
    end
  end

  // Loads return data only on an idle hit; a store wins over a load.
  always_comb begin
    rdata = 32'd0;
    if ((r_state == ST_IDLE) && w_hit && !MEM_W_EN) begin
      rdata = is_byte ? {24'd0, w_rbyte} : w_rword;
    end
  end

  assign block_pipe_data_cache = (r_state != ST_IDLE) | (w_access & ~w_hit);

  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wline    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss_idle) begin
          w_state_next = (r_valid[w_idx] && r_dirty[w_idx]) ? ST_EVICT : ST_FILL;
        end
      end
      ST_EVICT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_tag[r_req_idx], r_req_idx, {c_OFF_W{1'b0}}};
        mem_wline = r_data[r_req_idx];
        if (mem_ack) w_state_next = ST_FILL;
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_req_tag, r_req_idx, {c_OFF_W{1'b0}}};
        if (mem_ack) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The miss address is captured so the transfer stays stable independent of addr.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_req_idx <= '0;
      r_req_tag <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_miss_idle) begin
        r_req_idx <= w_idx;
        r_req_tag <= w_tag;
      end
      if (w_store_hit) r_dirty[w_idx] <= 1'b1;
      if (w_fill_done) begin
        r_valid[r_req_idx] <= 1'b1;
        r_dirty[r_req_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_store_hit) begin
        r_data[w_idx] <= w_wline;
      end else if (w_fill_done) begin
        r_data[r_req_idx] <= mem_rline;
        r_tag[r_req_idx]  <= r_req_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Scenario bench for dcache_ctrl with an expected-load queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         MEM_R_EN, MEM_W_EN, is_byte, mem_ack;
  logic [31:0]  addr, wdata, rdata, mem_addr;
  logic         block_pipe_data_cache, mem_req, mem_we;
  logic [127:0] mem_wline, mem_rline;

  int           checks   = 0;
  int           failures = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_v;
  bit           ok;

  localparam logic [127:0] c_LINE_A = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [127:0] c_LINE_B = {32'h0140000C, 32'h01400008, 32'h01400004, 32'h01400000};
  localparam logic [127:0] c_LINE_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'h11223344};
  localparam logic [127:0] c_LINE_D = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'h0210D1D1, 32'h0210D0D0};
  localparam logic [127:0] c_LINE_E = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'h0100E0E0};

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(4), .LINE_BYTES(16), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .is_byte(is_byte), .addr(addr), .wdata(wdata), .rdata(rdata),
    .block_pipe_data_cache(block_pipe_data_cache), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wline(mem_wline),
    .mem_rline(mem_rline), .mem_ack(mem_ack)
  );

  task automatic drive(input logic r, input logic w, input logic b,
                       input logic [31:0] a, input logic [31:0] d);
    MEM_R_EN = r; MEM_W_EN = w; is_byte = b; addr = a; wdata = d;
  endtask

  // Bounded wait for a memory request; an expired bound counts as a failure.
  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (mem_req === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL mem_req_timeout got=%b expected=1 within 20 cycles", mem_req);
    end
  endtask

  task automatic ack(input logic [127:0] line);
    mem_ack = 1'b1; mem_rline = line;
    @(negedge clk);
    mem_ack = 1'b0; mem_rline = '0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ack = 1'b0; mem_rline = '0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0; #1;
    checks++; if (block_pipe_data_cache !== 1'b0) begin failures++; $display("FAIL reset_block got=%b expected=0", block_pipe_data_cache); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b expected=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b expected=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h expected=0", mem_addr); end
    checks++; if (mem_wline !== 128'h0) begin failures++; $display("FAIL reset_mem_wline got=%h expected=0", mem_wline); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h expected=0", rdata); end
  endtask

  task automatic test_cold_fill();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h104, 32'h0); #1;
    checks++; if (block_pipe_data_cache !== 1'b1) begin failures++; $display("FAIL cold_block_same_cycle got=%b expected=1", block_pipe_data_cache); end
    wait_req(ok);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL cold_mem_we got=%b expected=0", mem_we); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL cold_mem_addr got=%h expected=00000100", mem_addr); end
    checks++; if (block_pipe_data_cache !== 1'b1) begin failures++; $display("FAIL cold_block_in_fill got=%b expected=1", block_pipe_data_cache); end
    exp_q.push_back(c_LINE_A[63:32]);
    ack(c_LINE_A);
    checks++; if (block_pipe_data_cache !== 1'b0) begin failures++; $display("FAIL cold_block_after_ack got=%b expected=0", block_pipe_data_cache); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_req_drop got=%b expected=0", mem_req); end
    exp_v = exp_q.pop_front();
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL cold_rdata got=%h expected=%h", rdata, exp_v); end
  endtask

  task automatic test_store_hit();
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h55AA1234); #1;
    checks++; if (block_pipe_data_cache !== 1'b0) begin failures++; $display("FAIL store_hit_block got=%b expected=0", block_pipe_data_cache); end
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    exp_q.push_back(32'h55AA1234); #1;
    checks++; if (block_pipe_data_cache !== 1'b0) begin failures++; $display("FAIL store_load_block got=%b expected=0", block_pipe_data_cache); end
    exp_v = exp_q.pop_front();
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL store_load_rdata got=%h expected=%h", rdata, exp_v); end
  endtask

  task automatic test_evict_fill();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h140, 32'h0); #1;
    checks++; if (block_pipe_data_cache !== 1'b1) begin failures++; $display("FAIL evict_block_same_cycle got=%b expected=1", block_pipe_data_cache); end
    wait_req(ok);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL evict_mem_we got=%b expected=1", mem_we); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL evict_mem_addr got=%h expected=00000100", mem_addr); end
    checks++; if (mem_wline[31:0] !== 32'h55AA1234) begin failures++; $display("FAIL evict_wline_w0 got=%h expected=55aa1234", mem_wline[31:0]); end
    checks++; if (mem_wline[63:32] !== c_LINE_A[63:32]) begin failures++; $display("FAIL evict_wline_w1 got=%h expected=%h", mem_wline[63:32], c_LINE_A[63:32]); end
    ack({4{32'hDEADBEEF}});
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL b2b_mem_req got=%b expected=1", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL b2b_mem_we got=%b expected=0", mem_we); end
    checks++; if (mem_addr !== 32'h140) begin failures++; $display("FAIL b2b_mem_addr got=%h expected=00000140", mem_addr); end
    checks++; if (block_pipe_data_cache !== 1'b1) begin failures++; $display("FAIL b2b_block got=%b expected=1", block_pipe_data_cache); end
    exp_q.push_back(c_LINE_B[31:0]);
    ack(c_LINE_B);
    checks++; if (block_pipe_data_cache !== 1'b0) begin failures++; $display("FAIL evict_block_after_fill got=%b expected=0", block_pipe_data_cache); end
    exp_v = exp_q.pop_front();
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL evict_rdata got=%h expected=%h", rdata, exp_v); end
  endtask

  task automatic test_byte_access();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0); #1;
    wait_req(ok);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL clean_victim_no_evict got=%b expected=0", mem_we); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL byte_fill_addr got=%h expected=00000100", mem_addr); end
    exp_q.push_back(32'h11223344);
    ack(c_LINE_C);
    exp_v = exp_q.pop_front();
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL byte_pre_rdata got=%h expected=%h", rdata, exp_v); end
    @(negedge clk); drive(1'b0, 1'b1, 1'b1, 32'h102, 32'h123456EF); #1;
    checks++; if (block_pipe_data_cache !== 1'b0) begin failures++; $display("FAIL byte_store_block got=%b expected=0", block_pipe_data_cache); end
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0); exp_q.push_back(32'h11EF3344); #1;
    exp_v = exp_q.pop_front();
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL byte_merge_word got=%h expected=%h", rdata, exp_v); end
    @(negedge clk); drive(1'b1, 1'b0, 1'b1, 32'h102, 32'h0); exp_q.push_back(32'h000000EF); #1;
    exp_v = exp_q.pop_front();
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL byte_load_lane2 got=%h expected=%h", rdata, exp_v); end
    @(negedge clk); drive(1'b1, 1'b0, 1'b1, 32'h103, 32'h0); exp_q.push_back(32'h00000011); #1;
    exp_v = exp_q.pop_front();
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL byte_load_lane3 got=%h expected=%h", rdata, exp_v); end
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h210, 32'h0); #1;
    wait_req(ok);
    checks++; if (mem_addr !== 32'h210) begin failures++; $display("FAIL abort_fill_addr got=%h expected=00000210", mem_addr); end
    reset = 1'b1; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL abort_mem_req got=%b expected=0", mem_req); end
    mem_ack = 1'b1; mem_rline = c_LINE_D;
    @(negedge clk); mem_ack = 1'b0; mem_rline = '0; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL late_ack_mem_req got=%b expected=0", mem_req); end
    checks++; if (block_pipe_data_cache !== 1'b0) begin failures++; $display("FAIL late_ack_block got=%b expected=0", block_pipe_data_cache); end
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h210, 32'h0); #1;
    checks++; if (block_pipe_data_cache !== 1'b1) begin failures++; $display("FAIL reaccess_miss got=%b expected=1", block_pipe_data_cache); end
    wait_req(ok);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reaccess_mem_we got=%b expected=0", mem_we); end
    exp_q.push_back(c_LINE_D[31:0]);
    ack(c_LINE_D);
    exp_v = exp_q.pop_front();
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL reaccess_rdata got=%h expected=%h", rdata, exp_v); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0); #1;
    wait_req(ok);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL b2b_setup_we got=%b expected=0", mem_we); end
    exp_q.push_back(c_LINE_E[31:0]);
    ack(c_LINE_E);
    exp_v = exp_q.pop_front();
    checks++; if (rdata !== exp_v) begin failures++; $display("FAIL b2b_setup_rdata got=%h expected=%h", rdata, exp_v); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0); exp_q.push_back(c_LINE_E[31:0]);
      end else begin
        drive(1'b1, 1'b0, 1'b0, 32'h214, 32'h0); exp_q.push_back(c_LINE_D[63:32]);
      end
      #1;
      checks++; if (block_pipe_data_cache !== 1'b0) begin failures++; $display("FAIL alt_block[%0d] got=%b expected=0", i, block_pipe_data_cache); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL alt_mem_req[%0d] got=%b expected=0", i, mem_req); end
      exp_v = exp_q.pop_front();
      checks++; if (rdata !== exp_v) begin failures++; $display("FAIL alt_rdata[%0d] got=%h expected=%h", i, rdata, exp_v); end
    end
  endtask

  task automatic test_idle();
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h100, 32'h0); mem_ack = 1'b1; #1;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL idle_rdata got=%h expected=0", rdata); end
    checks++; if (block_pipe_data_cache !== 1'b0) begin failures++; $display("FAIL idle_block got=%b expected=0", block_pipe_data_cache); end
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_ack_ignored got=%b expected=0", mem_req); end
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_store_hit();
    test_evict_fill();
    test_byte_access();
    test_reset_mid_fill();
    test_back_to_back();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
